// File: rtl/bsg_mem_one_hot_merge_ctrl.sv
// bsg_mem_one_hot_merge_ctrl
//
// Write-combining controller for a one-hot addressed, bit-masked register
// file. Producers allocate an entry, fill it with masked fragments in any
// order, and the entry drains once every bit has been written. Entries
// drain strictly in allocation order.
//
// State table (no FSM; per-entry state is the pair alloc_r/filled_r):
//   alloc=0              | free
//   alloc=1, filled!=1s  | allocated, collecting fragments
//   alloc=1, filled==1s  | complete, waits to become head, then drains
//
// Ports:
//   clk_i, reset_i             clock, synchronous active-high reset
//   alloc_v_i / alloc_ready_o  allocation handshake, alloc_id_o = one-hot id
//   frag_v_i, frag_id_i,       masked fragment write to an allocated entry
//   frag_mask_i, frag_data_i
//   mem_w_v_o/_mask_o/_data_o  write port to the memory
//   mem_r_v_o, mem_r_data_i    asynchronous read of the head entry
//   deq_v_o, deq_data_o,       head entry complete / consumer takes it
//   deq_yumi_i
//   err_o                      sticky illegal-fragment flag
module bsg_mem_one_hot_merge_ctrl #(
  parameter int width_p = 1,
  parameter int els_p   = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,

  input  logic               alloc_v_i,
  output logic               alloc_ready_o,
  output logic [els_p-1:0]   alloc_id_o,

  input  logic               frag_v_i,
  input  logic [els_p-1:0]   frag_id_i,
  input  logic [width_p-1:0] frag_mask_i,
  input  logic [width_p-1:0] frag_data_i,

  output logic [els_p-1:0]   mem_w_v_o,
  output logic [width_p-1:0] mem_w_mask_o,
  output logic [width_p-1:0] mem_w_data_o,
  output logic [els_p-1:0]   mem_r_v_o,
  input  logic [width_p-1:0] mem_r_data_i,

  output logic               deq_v_o,
  output logic [width_p-1:0] deq_data_o,
  input  logic               deq_yumi_i,

  output logic               err_o
);

  // A one-entry controller still carries a 1-bit pointer that never moves.
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] els_cnt_lp  = cnt_w_lp'(els_p);
  localparam logic [els_p-1:0]    one_lp      = els_p'(1);

  logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic [els_p-1:0]    alloc_r;
  logic [width_p-1:0]  filled_r [els_p];
  logic                err_r;

  logic               alloc_fire, deq_fire, frag_legal;
  logic [width_p-1:0] sel_filled;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + 1'b1;
  endfunction

  assign alloc_ready_o = (count_r < els_cnt_lp);
  assign alloc_id_o    = one_lp << wr_ptr_r;
  assign alloc_fire    = alloc_v_i & alloc_ready_o;

  // Fill state of the fragment's target; only meaningful when frag_id_i is
  // one-hot, which frag_legal also requires.
  always_comb begin
    sel_filled = '0;
    for (int i = 0; i < els_p; i++)
      if (frag_id_i[i]) sel_filled = sel_filled | filled_r[i];
  end

  assign frag_legal = frag_v_i & $onehot(frag_id_i)
                    & (|(frag_id_i & alloc_r)) & ~(&sel_filled);

  assign mem_w_v_o    = (frag_legal & ~reset_i) ? frag_id_i : '0;
  assign mem_w_mask_o = frag_mask_i;
  assign mem_w_data_o = frag_data_i;

  assign mem_r_v_o  = one_lp << rd_ptr_r;
  assign deq_v_o    = alloc_r[rd_ptr_r] & (&filled_r[rd_ptr_r]);
  assign deq_data_o = mem_r_data_i;
  // A yumi without a valid head is ignored.
  assign deq_fire   = deq_yumi_i & deq_v_o;

  assign err_o = err_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      alloc_r  <= '0;
      err_r    <= 1'b0;
      for (int i = 0; i < els_p; i++) filled_r[i] <= '0;
    end else begin
      if (alloc_fire) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (deq_fire)   rd_ptr_r <= ptr_inc(rd_ptr_r);

      case ({alloc_fire, deq_fire})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase

      if (frag_v_i & ~frag_legal) err_r <= 1'b1;

      // Allocation, dequeue and a legal fragment never target the same
      // entry in one cycle: a free entry cannot be the valid head, and a
      // legal fragment needs an allocated, incomplete entry.
      for (int i = 0; i < els_p; i++) begin
        if (alloc_fire && (wr_ptr_r == ptr_w_lp'(i))) begin
          alloc_r[i]  <= 1'b1;
          filled_r[i] <= '0;
        end else if (deq_fire && (rd_ptr_r == ptr_w_lp'(i))) begin
          alloc_r[i]  <= 1'b0;
          filled_r[i] <= '0;
        end else if (frag_legal && frag_id_i[i]) begin
          filled_r[i] <= filled_r[i] | frag_mask_i;
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(deq_yumi_i && !deq_v_o))
        else $error("deq_yumi_i asserted while deq_v_o is 0");
      // Multi-hot ids are a producer bug but are handled (flagged in err_o),
      // so this reports without stopping the run.
      assert (!frag_v_i || $onehot0(frag_id_i))
        else $warning("frag_id_i is not one-hot or zero");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mem_one_hot_merge_ctrl.sv
module tb_bsg_mem_one_hot_merge_ctrl;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         alloc_v_i = 1'b0;
  logic         alloc_ready_o;
  logic [N-1:0] alloc_id_o;
  logic         frag_v_i = 1'b0;
  logic [N-1:0] frag_id_i = '0;
  logic [W-1:0] frag_mask_i = '0;
  logic [W-1:0] frag_data_i = '0;
  logic [N-1:0] mem_w_v_o;
  logic [W-1:0] mem_w_mask_o, mem_w_data_o;
  logic [N-1:0] mem_r_v_o;
  logic [W-1:0] mem_r_data_i;
  logic         deq_v_o;
  logic [W-1:0] deq_data_o;
  logic         deq_yumi_i = 1'b0;
  logic         err_o;

  always #5 clk = ~clk;

  bsg_mem_one_hot_merge_ctrl #(.width_p(W), .els_p(N)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .alloc_v_i(alloc_v_i), .alloc_ready_o(alloc_ready_o), .alloc_id_o(alloc_id_o),
    .frag_v_i(frag_v_i), .frag_id_i(frag_id_i), .frag_mask_i(frag_mask_i),
    .frag_data_i(frag_data_i),
    .mem_w_v_o(mem_w_v_o), .mem_w_mask_o(mem_w_mask_o), .mem_w_data_o(mem_w_data_o),
    .mem_r_v_o(mem_r_v_o), .mem_r_data_i(mem_r_data_i),
    .deq_v_o(deq_v_o), .deq_data_o(deq_data_o), .deq_yumi_i(deq_yumi_i),
    .err_o(err_o)
  );

  // Bit-masked memory with asynchronous one-hot read.
  logic [W-1:0] mem [N];
  initial for (int i = 0; i < N; i++) mem[i] = '0;
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (mem_w_v_o[i]) mem[i] <= (mem[i] & ~mem_w_mask_o) | (mem_w_data_o & mem_w_mask_o);
  always_comb begin
    mem_r_data_i = '0;
    for (int i = 0; i < N; i++) if (mem_r_v_o[i]) mem_r_data_i = mem_r_data_i | mem[i];
  end

  int passed = 0;
  int total  = 0;

  // Scoreboard: entry indices in allocation order, and expected entry data
  // built from the fragments the bench drives as legal.
  int           sb_q[$];
  logic [W-1:0] model [N];
  initial for (int i = 0; i < N; i++) model[i] = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int idx(input logic [N-1:0] oh);
    int r = 0;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic logic [N-1:0] oh_of(input int i);
    logic [N-1:0] one = 1;
    return one << i;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    reset_i = 1'b1;
    repeat (cycles) tick();
    reset_i = 1'b0;
    sb_q.delete();
  endtask

  task automatic do_alloc(input logic [N-1:0] exp_id, input string tag);
    alloc_v_i = 1'b1;
    #1;
    check({tag, " ready"}, 32'(alloc_ready_o), 32'd1);
    check({tag, " id"}, 32'(alloc_id_o), 32'(exp_id));
    tick();
    alloc_v_i = 1'b0;
    sb_q.push_back(idx(exp_id));
  endtask

  task automatic frag(input logic [N-1:0] id, input logic [W-1:0] mask,
                      input logic [W-1:0] data, input bit legal, input string tag);
    frag_v_i = 1'b1; frag_id_i = id; frag_mask_i = mask; frag_data_i = data;
    #1;
    check({tag, " w_v"}, 32'(mem_w_v_o), legal ? 32'(id) : 32'd0);
    tick();
    frag_v_i = 1'b0;
    if (legal) model[idx(id)] = (model[idx(id)] & ~mask) | (data & mask);
  endtask

  task automatic pop(input string tag);
    int n = 0;
    int e;
    while (!deq_v_o && n < 8) begin tick(); n++; end
    check({tag, " deq_v"}, 32'(deq_v_o), 32'd1);
    if (sb_q.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty at dequeue", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, " r_v"}, 32'(mem_r_v_o), 32'(oh_of(e)));
      check({tag, " data"}, 32'(deq_data_o), 32'(model[e]));
    end
    deq_yumi_i = deq_v_o;
    tick();
    deq_yumi_i = 1'b0;
  endtask

  initial begin
    // Reset, with a fragment driven to confirm the write select is held off.
    #1;
    frag_v_i = 1'b1; frag_id_i = 4'b0001; frag_mask_i = 8'hFF; frag_data_i = 8'hEE;
    repeat (2) tick();
    check("rst ready", 32'(alloc_ready_o), 32'd1);
    check("rst id", 32'(alloc_id_o), 32'b0001);
    check("rst deq_v", 32'(deq_v_o), 32'd0);
    check("rst err", 32'(err_o), 32'd0);
    check("rst w_v", 32'(mem_w_v_o), 32'd0);
    check("rst r_v", 32'(mem_r_v_o), 32'b0001);
    frag_v_i = 1'b0;
    reset_i = 1'b0;

    // Two-fragment merge.
    do_alloc(4'b0001, "merge alloc");
    frag(4'b0001, 8'h0F, 8'hA5, 1, "merge f0");
    check("merge partial deq_v", 32'(deq_v_o), 32'd0);
    frag(4'b0001, 8'hF0, 8'h3C, 1, "merge f1");
    check("merge next-cycle deq_v", 32'(deq_v_o), 32'd1);
    check("merge data const", 32'(deq_data_o), 32'h35);
    pop("merge pop");
    check("merge after deq_v", 32'(deq_v_o), 32'd0);

    // Fill to full, out-of-order completion, allocate+yumi at full.
    do_reset(1);
    for (int i = 0; i < N; i++) do_alloc(oh_of(i), "fill alloc");
    check("full ready", 32'(alloc_ready_o), 32'd0);
    alloc_v_i = 1'b1;
    tick();
    alloc_v_i = 1'b0;
    check("full 5th ready", 32'(alloc_ready_o), 32'd0);
    check("full 5th id", 32'(alloc_id_o), 32'b0001);
    frag(4'b0010, 8'hFF, 8'h11, 1, "ooo e1");
    check("ooo e1 done deq_v", 32'(deq_v_o), 32'd0);
    frag(4'b0001, 8'h01, 8'h22, 1, "ooo e0a");
    check("ooo e0 partial deq_v", 32'(deq_v_o), 32'd0);
    frag(4'b0001, 8'hFE, 8'h22, 1, "ooo e0b");
    check("ooo e0 data const", 32'(deq_data_o), 32'h22);
    alloc_v_i = 1'b1;
    #1;
    check("full+yumi ready", 32'(alloc_ready_o), 32'd0);
    pop("full pop e0");
    alloc_v_i = 1'b0;
    check("count3 ready", 32'(alloc_ready_o), 32'd1);
    pop("full pop e1");
    check("drain head2 deq_v", 32'(deq_v_o), 32'd0);
    do_alloc(4'b0001, "realloc a");
    do_alloc(4'b0010, "realloc b");
    check("refull ready", 32'(alloc_ready_o), 32'd0);

    // Illegal fragments.
    do_reset(1);
    check("ill err init", 32'(err_o), 32'd0);
    frag(4'b0100, 8'hFF, 8'h99, 0, "ill unalloc");
    check("ill unalloc err", 32'(err_o), 32'd1);
    alloc_v_i = 1'b1;
    frag_v_i = 1'b1; frag_id_i = 4'b0001; frag_mask_i = 8'hFF; frag_data_i = 8'h66;
    #1;
    check("ill accept-cycle w_v", 32'(mem_w_v_o), 32'd0);
    tick();
    alloc_v_i = 1'b0; frag_v_i = 1'b0;
    sb_q.push_back(0);
    check("ill accept-cycle deq_v", 32'(deq_v_o), 32'd0);
    frag(4'b0001, 8'hFF, 8'h77, 1, "ill fill e0");
    frag(4'b0001, 8'h0F, 8'h00, 0, "ill complete");
    frag(4'b0011, 8'hFF, 8'h00, 0, "ill two-hot");
    do_alloc(4'b0010, "ill alloc e1");
    frag(4'b0010, 8'h00, 8'hFF, 1, "mask0");
    pop("ill pop e0");
    check("mask0 no fill deq_v", 32'(deq_v_o), 32'd0);
    check("ill err sticky", 32'(err_o), 32'd1);

    // Wrap-around, then reset in the middle of a fill.
    do_reset(1);
    for (int i = 0; i < N; i++) begin
      do_alloc(oh_of(i), "wrap alloc");
      frag(oh_of(i), 8'hFF, 8'(8'h40 + i), 1, "wrap fill");
      pop("wrap pop");
    end
    check("wrap id", 32'(alloc_id_o), 32'b0001);
    check("wrap r_v", 32'(mem_r_v_o), 32'b0001);
    do_alloc(4'b0001, "wrap realloc");
    frag(4'b0001, 8'h0F, 8'h5A, 1, "mid f0");
    reset_i = 1'b1;
    frag(4'b0001, 8'hF0, 8'hC3, 0, "mid rst f1");
    reset_i = 1'b0;
    sb_q.delete();
    check("mid deq_v", 32'(deq_v_o), 32'd0);
    check("mid ready", 32'(alloc_ready_o), 32'd1);
    check("mid id", 32'(alloc_id_o), 32'b0001);
    check("mid r_v", 32'(mem_r_v_o), 32'b0001);
    check("mid err", 32'(err_o), 32'd0);
    check("mid mem kept", 32'(mem[0]), 32'(model[0]));
    frag(4'b0001, 8'hF0, 8'h00, 0, "mid freed");
    check("mid freed err", 32'(err_o), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
